// File: rtl/br_commit_tracker.sv
// br_commit_tracker
//
// Holds branch prediction metadata captured at fetch in an in-order queue.
// When EX resolves a control transfer, the resolution is paired with the
// oldest queued entry. A registered EXMEM_* update/recovery packet is then
// driven back into the agree predictor.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   IF_push_i, IF_pc_i,      enqueue metadata of a correct-path B-type/JAL
//   IF_btb_hit_i, IF_prediction_i, IF_bias_i, IF_ghr_data_i
//   EX_resolve_i, EX_is_jmp_i, EX_br_decision_i, EX_br_target_i
//                            resolution from EX (is_jmp=0 means JALR)
//   flush_i                  discard all queued entries
//   IF_full_o, count_o       occupancy, combinational from the count register
//   EXMEM_*                  registered commit packet, valid for one cycle
//   mispredict_o             registered; the packet is a redirect
//   err_o                    sticky overflow / empty-resolve error
//   stat_branches_o, stat_mispred_o  saturating performance counters
//
// Configuration macro: BR_COMMIT_STATS_EN enables the performance counters.
// When it is undefined, both stat outputs are tied to zero.
`timescale 1ns/1ps
module br_commit_tracker #(
  parameter int unsigned INDEX_WIDTH   = 6,
  parameter int unsigned HISTORY_WIDTH = 8,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          IF_push_i,
  input  logic [31:0]                   IF_pc_i,
  input  logic                          IF_btb_hit_i,
  input  logic                          IF_prediction_i,
  input  logic                          IF_bias_i,
  input  logic [HISTORY_WIDTH-1:0]      IF_ghr_data_i,
  input  logic                          EX_resolve_i,
  input  logic                          EX_is_jmp_i,
  input  logic                          EX_br_decision_i,
  input  logic [31:0]                   EX_br_target_i,
  input  logic                          flush_i,
  output logic                          IF_full_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          EXMEM_is_jmp_o,
  output logic                          EXMEM_br_decision_o,
  output logic                          EXMEM_prediction_o,
  output logic                          EXMEM_btb_hit_o,
  output logic                          EXMEM_bias_o,
  output logic [HISTORY_WIDTH-1:0]      EXMEM_ghr_data_o,
  output logic [INDEX_WIDTH-1:0]        EXMEM_btb_wr_index_o,
  output logic [32-INDEX_WIDTH-2-1:0]   EXMEM_btb_wr_tag_o,
  output logic [31:0]                   EXMEM_btb_wr_target_o,
  output logic [HISTORY_WIDTH-1:0]      EXMEM_pht_wr_index_o,
  output logic                          mispredict_o,
  output logic                          err_o,
  output logic [31:0]                   stat_branches_o,
  output logic [31:0]                   stat_mispred_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TagW = 32 - INDEX_WIDTH - 2;

  // Queue storage; contents are qualified by count_q, so no reset is needed.
  logic [31:0]              pc_mem_q   [DEPTH];
  logic                     hit_mem_q  [DEPTH];
  logic                     pred_mem_q [DEPTH];
  logic                     bias_mem_q [DEPTH];
  logic [HISTORY_WIDTH-1:0] ghr_mem_q  [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic                     is_jmp_q, is_jmp_d;
  logic                     dec_q, dec_d;
  logic                     pred_q, pred_d;
  logic                     hit_q, hit_d;
  logic                     bias_q, bias_d;
  logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d;
  logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
  logic [TagW-1:0]          tag_q, tag_d;
  logic [31:0]              tgt_q, tgt_d;
  logic [HISTORY_WIDTH-1:0] pht_q, pht_d;
  logic                     mis_q, mis_d;

  logic                     hd_valid;
  logic [31:0]              hd_pc;
  logic                     hd_hit, hd_pred, hd_bias;
  logic [HISTORY_WIDTH-1:0] hd_ghr;
  logic                     full;
  logic                     res_br;
  logic                     pop;
  logic                     mispred;
  logic                     clear;
  logic                     push_ok;
  logic                     unused_pc;

  assign unused_pc = ^hd_pc[1:0];

  // Head metadata reads as zero when the queue is empty.
  assign hd_valid = (count_q != '0);
  assign hd_pc    = hd_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign hd_hit   = hd_valid ? hit_mem_q[rd_ptr_q]  : 1'b0;
  assign hd_pred  = hd_valid ? pred_mem_q[rd_ptr_q] : 1'b0;
  assign hd_bias  = hd_valid ? bias_mem_q[rd_ptr_q] : 1'b0;
  assign hd_ghr   = hd_valid ? ghr_mem_q[rd_ptr_q]  : '0;

  assign full    = (count_q == CntW'(DEPTH));
  assign res_br  = EX_resolve_i & EX_is_jmp_i;
  assign pop     = res_br & hd_valid;
  // JALR always redirects; a branch redirects when the fetch guess was wrong.
  assign mispred = EX_resolve_i & (~EX_is_jmp_i | (hd_pred ^ EX_br_decision_i));
  assign clear   = flush_i | mispred;
  // A pop frees a slot in the same cycle, so push+pop is legal when full.
  assign push_ok = IF_push_i & (~full | pop) & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + CntW'(push_ok) - CntW'(pop);
    end
  end

  // A push discarded as wrong-path (clear) is not an overflow.
  assign err_d = err_q | (IF_push_i & full & ~pop & ~clear) | (res_br & ~hd_valid);

  always_comb begin
    is_jmp_d = 1'b0;
    dec_d    = 1'b0;
    pred_d   = 1'b0;
    hit_d    = 1'b0;
    bias_d   = 1'b0;
    ghr_d    = '0;
    idx_d    = '0;
    tag_d    = '0;
    tgt_d    = '0;
    pht_d    = '0;
    mis_d    = 1'b0;
    if (EX_resolve_i) begin
      is_jmp_d = EX_is_jmp_i;
      dec_d    = EX_is_jmp_i ? EX_br_decision_i : 1'b1;
      tgt_d    = EX_br_target_i;
      mis_d    = mispred;
      if (EX_is_jmp_i) begin
        pred_d = hd_pred;
        hit_d  = hd_hit;
        bias_d = hd_bias;
        ghr_d  = hd_ghr;
        idx_d  = hd_pc[INDEX_WIDTH+1:2];
        tag_d  = hd_pc[31:INDEX_WIDTH+2];
        pht_d  = hd_pc[HISTORY_WIDTH+1:2];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      pc_mem_q[wr_ptr_q]   <= IF_pc_i;
      hit_mem_q[wr_ptr_q]  <= IF_btb_hit_i;
      pred_mem_q[wr_ptr_q] <= IF_prediction_i;
      bias_mem_q[wr_ptr_q] <= IF_bias_i;
      ghr_mem_q[wr_ptr_q]  <= IF_ghr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      is_jmp_q <= 1'b0;
      dec_q    <= 1'b0;
      pred_q   <= 1'b0;
      hit_q    <= 1'b0;
      bias_q   <= 1'b0;
      ghr_q    <= '0;
      idx_q    <= '0;
      tag_q    <= '0;
      tgt_q    <= '0;
      pht_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      is_jmp_q <= is_jmp_d;
      dec_q    <= dec_d;
      pred_q   <= pred_d;
      hit_q    <= hit_d;
      bias_q   <= bias_d;
      ghr_q    <= ghr_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      tgt_q    <= tgt_d;
      pht_q    <= pht_d;
      mis_q    <= mis_d;
    end
  end

`ifdef BR_COMMIT_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  // Saturating counters, updated at the same edge as the packet.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (EX_resolve_i && (stat_br_q != 32'hFFFF_FFFF)) stat_br_d = stat_br_q + 32'd1;
    if (mispred && (stat_mp_q != 32'hFFFF_FFFF))      stat_mp_d = stat_mp_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o = stat_br_q;
  assign stat_mispred_o  = stat_mp_q;
`else
  assign stat_branches_o = '0;
  assign stat_mispred_o  = '0;
`endif

  assign IF_full_o             = full;
  assign count_o               = count_q;
  assign EXMEM_is_jmp_o        = is_jmp_q;
  assign EXMEM_br_decision_o   = dec_q;
  assign EXMEM_prediction_o    = pred_q;
  assign EXMEM_btb_hit_o       = hit_q;
  assign EXMEM_bias_o          = bias_q;
  assign EXMEM_ghr_data_o      = ghr_q;
  assign EXMEM_btb_wr_index_o  = idx_q;
  assign EXMEM_btb_wr_tag_o    = tag_q;
  assign EXMEM_btb_wr_target_o = tgt_q;
  assign EXMEM_pht_wr_index_o  = pht_q;
  assign mispredict_o          = mis_q;
  assign err_o                 = err_q;

endmodule

// File: tb/tb_br_commit_tracker.sv
// Self-checking bench for br_commit_tracker: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_br_commit_tracker;

  localparam int IW = 6;
  localparam int HW = 8;
  localparam int D  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          IF_push_i, IF_btb_hit_i, IF_prediction_i, IF_bias_i;
  logic [31:0]   IF_pc_i;
  logic [HW-1:0] IF_ghr_data_i;
  logic          EX_resolve_i, EX_is_jmp_i, EX_br_decision_i;
  logic [31:0]   EX_br_target_i;
  logic          flush_i;
  logic          IF_full_o;
  logic [2:0]    count_o;
  logic          EXMEM_is_jmp_o, EXMEM_br_decision_o, EXMEM_prediction_o;
  logic          EXMEM_btb_hit_o, EXMEM_bias_o;
  logic [HW-1:0] EXMEM_ghr_data_o;
  logic [IW-1:0] EXMEM_btb_wr_index_o;
  logic [23:0]   EXMEM_btb_wr_tag_o;
  logic [31:0]   EXMEM_btb_wr_target_o;
  logic [HW-1:0] EXMEM_pht_wr_index_o;
  logic          mispredict_o, err_o;
  logic [31:0]   stat_branches_o, stat_mispred_o;

  br_commit_tracker #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW), .DEPTH(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IF_push_i(IF_push_i), .IF_pc_i(IF_pc_i), .IF_btb_hit_i(IF_btb_hit_i),
    .IF_prediction_i(IF_prediction_i), .IF_bias_i(IF_bias_i), .IF_ghr_data_i(IF_ghr_data_i),
    .EX_resolve_i(EX_resolve_i), .EX_is_jmp_i(EX_is_jmp_i),
    .EX_br_decision_i(EX_br_decision_i), .EX_br_target_i(EX_br_target_i),
    .flush_i(flush_i), .IF_full_o(IF_full_o), .count_o(count_o),
    .EXMEM_is_jmp_o(EXMEM_is_jmp_o), .EXMEM_br_decision_o(EXMEM_br_decision_o),
    .EXMEM_prediction_o(EXMEM_prediction_o), .EXMEM_btb_hit_o(EXMEM_btb_hit_o),
    .EXMEM_bias_o(EXMEM_bias_o), .EXMEM_ghr_data_o(EXMEM_ghr_data_o),
    .EXMEM_btb_wr_index_o(EXMEM_btb_wr_index_o), .EXMEM_btb_wr_tag_o(EXMEM_btb_wr_tag_o),
    .EXMEM_btb_wr_target_o(EXMEM_btb_wr_target_o),
    .EXMEM_pht_wr_index_o(EXMEM_pht_wr_index_o),
    .mispredict_o(mispredict_o), .err_o(err_o),
    .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0]   pc;
    logic          hit, pred, bias;
    logic [HW-1:0] ghr;
  } ent_t;

  ent_t          q[$];
  logic          m_err;
  logic [31:0]   m_br, m_mp;
  logic          e_is_jmp, e_dec, e_pred, e_hit, e_bias, e_mis;
  logic [HW-1:0] e_ghr;
  logic [31:0]   e_pc, e_tgt;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Reference: what one clock edge must do, from the queue's observable rules.
  task automatic model_step();
    ent_t h;
    logic popped, mis;
    {e_is_jmp, e_dec, e_pred, e_hit, e_bias, e_mis} = '0;
    e_ghr = '0; e_pc = '0; e_tgt = '0;
    if (rst_i) begin
      q.delete(); m_err = 0; m_br = 0; m_mp = 0;
      return;
    end
    popped = 0; mis = 0;
    if (EX_resolve_i) begin
      e_is_jmp = EX_is_jmp_i;
      e_tgt    = EX_br_target_i;
      if (EX_is_jmp_i) begin
        if (q.size() > 0) begin h = q[0]; popped = 1; end
        else begin h = '0; m_err = 1; end
        e_dec = EX_br_decision_i;
        e_pc = h.pc; e_pred = h.pred; e_hit = h.hit; e_bias = h.bias; e_ghr = h.ghr;
        mis = h.pred ^ EX_br_decision_i;
      end else begin
        e_dec = 1; mis = 1;
      end
      e_mis = mis;
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (mis && m_mp != 32'hFFFF_FFFF) m_mp++;
    end
    if (flush_i || mis) q.delete();
    else begin
      if (popped) void'(q.pop_front());
      if (IF_push_i) begin
        if (q.size() < D) q.push_back('{IF_pc_i, IF_btb_hit_i, IF_prediction_i, IF_bias_i,
                                        IF_ghr_data_i});
        else m_err = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] sb, sm;
`ifdef BR_COMMIT_STATS_EN
    sb = m_br; sm = m_mp;
`else
    sb = 0; sm = 0;
`endif
    chk("count",    32'(count_o), 32'(q.size()));
    chk("full",     32'(IF_full_o), 32'(q.size() == D));
    chk("err",      32'(err_o), 32'(m_err));
    chk("is_jmp",   32'(EXMEM_is_jmp_o), 32'(e_is_jmp));
    chk("decision", 32'(EXMEM_br_decision_o), 32'(e_dec));
    chk("pred",     32'(EXMEM_prediction_o), 32'(e_pred));
    chk("hit",      32'(EXMEM_btb_hit_o), 32'(e_hit));
    chk("bias",     32'(EXMEM_bias_o), 32'(e_bias));
    chk("ghr",      32'(EXMEM_ghr_data_o), 32'(e_ghr));
    chk("index",    32'(EXMEM_btb_wr_index_o), (e_pc >> 2) & 32'h3F);
    chk("tag",      32'(EXMEM_btb_wr_tag_o), e_pc >> (IW + 2));
    chk("pht",      32'(EXMEM_pht_wr_index_o), (e_pc >> 2) & 32'hFF);
    chk("target",   EXMEM_btb_wr_target_o, e_tgt);
    chk("mispred",  32'(mispredict_o), 32'(e_mis));
    chk("stat_br",  stat_branches_o, sb);
    chk("stat_mp",  stat_mispred_o, sm);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst_i = 0; IF_push_i = 0; IF_pc_i = 0; IF_btb_hit_i = 0; IF_prediction_i = 0;
    IF_bias_i = 0; IF_ghr_data_i = 0; EX_resolve_i = 0; EX_is_jmp_i = 0;
    EX_br_decision_i = 0; EX_br_target_i = 0; flush_i = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pred);
    IF_push_i = 1; IF_pc_i = pc; IF_btb_hit_i = 1; IF_prediction_i = pred;
    IF_bias_i = pc[2]; IF_ghr_data_i = pc[11:4];
  endtask

  task automatic resolve(input logic jmp, input logic dec, input logic [31:0] tgt);
    EX_resolve_i = 1; EX_is_jmp_i = jmp; EX_br_decision_i = dec; EX_br_target_i = tgt;
  endtask

  task automatic do_reset();
    idle(); rst_i = 1; cyc(); cyc(); idle();
  endtask

  initial begin
    idle();
    m_err = 0; m_br = 0; m_mp = 0;
    do_reset();
    chk("rst_count", 32'(count_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_full", 32'(IF_full_o), 0);

    // Basic push then matching resolve.
    IF_push_i = 1; IF_pc_i = 32'h40; IF_btb_hit_i = 1; IF_prediction_i = 1; IF_bias_i = 1;
    IF_ghr_data_i = 8'h5A; cyc(); idle();
    resolve(1, 1, 32'h80); cyc(); idle();
    chk("t1_index", 32'(EXMEM_btb_wr_index_o), 32'h10);
    chk("t1_tag", 32'(EXMEM_btb_wr_tag_o), 0);
    chk("t1_pht", 32'(EXMEM_pht_wr_index_o), 32'h10);
    chk("t1_ghr", 32'(EXMEM_ghr_data_o), 32'h5A);
    chk("t1_target", EXMEM_btb_wr_target_o, 32'h80);
    chk("t1_mispred", 32'(mispredict_o), 0);
    chk("t1_count", 32'(count_o), 0);
    cyc();
    chk("t1_pkt_one_cycle", EXMEM_btb_wr_target_o, 0);

    // Fill, overflow, then push+pop while full.
    for (int i = 0; i < 4; i++) begin push(32'h100 + 32'(i) * 4, 1); cyc(); end
    idle();
    chk("t2_full", 32'(IF_full_o), 1);
    push(32'h200, 1); cyc(); idle();
    chk("t2_err", 32'(err_o), 1);
    chk("t2_count4", 32'(count_o), 4);
    push(32'h204, 1); resolve(1, 1, 32'h300); cyc(); idle();
    chk("t2_pushpop_count", 32'(count_o), 4);
    chk("t2_head_index", 32'(EXMEM_btb_wr_index_o), 32'h100 >> 2 & 32'h3F);
    do_reset();

    // Mispredict discards younger entries and same-cycle push.
    push(32'h400, 0); cyc(); push(32'h404, 1); cyc();
    idle(); push(32'h408, 1); resolve(1, 1, 32'h500); cyc(); idle();
    chk("t3_mispred", 32'(mispredict_o), 1);
    chk("t3_count", 32'(count_o), 0);

    // JALR with two queued entries.
    push(32'h600, 1); cyc(); push(32'h604, 1); cyc(); idle();
    resolve(0, 0, 32'h200); cyc(); idle();
    chk("t4_is_jmp", 32'(EXMEM_is_jmp_o), 0);
    chk("t4_dec", 32'(EXMEM_br_decision_o), 1);
    chk("t4_target", EXMEM_btb_wr_target_o, 32'h200);
    chk("t4_count", 32'(count_o), 0);
    chk("t4_err", 32'(err_o), 0);

    // Flush with push on count=3, then resolve on empty.
    for (int i = 0; i < 3; i++) begin push(32'h700 + 32'(i) * 4, 1); cyc(); end
    flush_i = 1; push(32'h70C, 1); cyc(); idle();
    chk("t5_count", 32'(count_o), 0);
    chk("t5_err", 32'(err_o), 0);
    resolve(1, 0, 32'h900); cyc(); idle();
    chk("t5_empty_err", 32'(err_o), 1);

    // Ten resolves, three of them mispredicts.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      push(32'h1000 + 32'(k) * 4, 1); cyc(); idle();
      resolve(1, (k >= 3), 32'h2000); cyc(); idle();
    end
`ifdef BR_COMMIT_STATS_EN
    chk("t6_stat_br", stat_branches_o, 10);
    chk("t6_stat_mp", stat_mispred_o, 3);
`else
    chk("t6_stat_br", stat_branches_o, 0);
    chk("t6_stat_mp", stat_mispred_o, 0);
`endif

    // Random traffic, including mid-run resets and pushes past full.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst_i = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) push($urandom, 1'($urandom));
      IF_btb_hit_i = 1'($urandom);
      IF_ghr_data_i = 8'($urandom);
      if ($urandom_range(0, 9) < 4)
        resolve(($urandom_range(0, 4) != 0), 1'($urandom), $urandom);
      flush_i = ($urandom_range(0, 19) == 0);
      cyc();
    end
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/br_commit_tracker.md
# br_commit_tracker

Branch commit tracker between the IF-stage agree predictor and the EX/MEM branch commit point. It holds the prediction metadata captured at fetch in a small in-order queue: BTB hit, prediction, bias bit, GHR snapshot and PC. When EX resolves a branch, it pairs the resolution with the oldest queued entry and drives the registered `EXMEM_*` update/recovery packet back into the predictor. It also clears wrong-path entries on redirect.

## Interface
- `INDEX_WIDTH`, default 6: BTB index width; tag width is 32-INDEX_WIDTH-2.
- `HISTORY_WIDTH`, default 8: GHR/PHT index width.
- `DEPTH`, default 4: queue entries; power of two, ≥2.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `IF_push_i` in 1: B-type/JAL leaving IF on the correct path; enqueue metadata.
- `IF_pc_i` in 32: PC of the pushed instruction.
- `IF_btb_hit_i`, `IF_prediction_i`, `IF_bias_i` in 1 each: predictor outputs at fetch.
- `IF_ghr_data_i` in HISTORY_WIDTH: GHR value used for the fetch prediction.
- `EX_resolve_i` in 1: EX resolved a control-transfer instruction this cycle.
- `EX_is_jmp_i` in 1: 1 for B-type/JAL, 0 for JALR.
- `EX_br_decision_i` in 1: actual outcome; always 1 for JAL and JALR.
- `EX_br_target_i` in 32: resolved target.
- `flush_i` in 1: external flush; discards all queued entries.
- `IF_full_o` out 1: queue full; fetch must stall before pushing.
- `count_o` out $clog2(DEPTH)+1: occupancy.
- `EXMEM_is_jmp_o`, `EXMEM_br_decision_o`, `EXMEM_prediction_o`, `EXMEM_btb_hit_o`, `EXMEM_bias_o` out 1 each: commit packet.
- `EXMEM_ghr_data_o` out HISTORY_WIDTH: GHR snapshot of the committing branch.
- `EXMEM_btb_wr_index_o` out INDEX_WIDTH: PC[INDEX_WIDTH+1:2].
- `EXMEM_btb_wr_tag_o` out 32-INDEX_WIDTH-2: PC[31:INDEX_WIDTH+2].
- `EXMEM_btb_wr_target_o` out 32: resolved target.
- `EXMEM_pht_wr_index_o` out HISTORY_WIDTH: PC[HISTORY_WIDTH+1:2].
- `mispredict_o` out 1: registered; the packet on the outputs is a redirect.
- `err_o` out 1: sticky; set on overflow push or on a resolve with an empty queue.
- `stat_branches_o`, `stat_mispred_o` out 32 each: performance counters.

## Operation
- Circular FIFO with read/write pointers of $clog2(DEPTH) bits plus a count. Pointers wrap modulo DEPTH.
- Push: when `IF_push_i` and not full, write metadata at the write pointer.
- Resolve with `EX_is_jmp_i`=1:
  - Pop the head.
  - Packet = head metadata plus the EX decision and target.
  - Mispredict = head.prediction XOR `EX_br_decision_i`.
- Resolve with `EX_is_jmp_i`=0 (JALR):
  - No pop.
  - Packet: is_jmp=0, decision=1; all other fields zero except target.
  - Always treated as a mispredict (redirect).
- On mispredict: the queue is cleared at the same edge (count=0, pointers=0). Any same-cycle push is dropped, because it is wrong-path.
- `flush_i`: same clear as a mispredict. Flush wins over push and over the pop bookkeeping; a same-cycle resolve packet is still emitted.
- Push and pop in the same cycle without a mispredict: count unchanged. Allowed even when full.
- Push when full (no same-cycle pop): dropped, `err_o` set.
- Resolve with is_jmp=1 on an empty queue: the packet emits the EX fields with metadata zero, and `err_o` is set.
- No resolve: the packet is all zeros. Idle is_jmp=0 with decision=0 leaves the predictor on its own prediction.

## Timing
- Packet, `mispredict_o` and stats: registered; 1-cycle latency from `EX_resolve_i` to the `EXMEM_*` outputs, valid for exactly one cycle.
- `IF_full_o` and `count_o`: combinational from the count register.
- Reset: all outputs 0, queue empty, `err_o`=0, counters 0. Reset mid-operation discards all entries and any pending packet.
- Back-to-back resolves every cycle are supported; each produces one packet on consecutive cycles.

## Configuration
- `BR_COMMIT_STATS_EN` defined:
  - `stat_branches_o` increments on each resolve.
  - `stat_mispred_o` increments on each mispredict.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and update at the packet edge.
- Not defined: both outputs tied to 0, and no counter flops exist.

## Test plan
- Reset, then push PC=0x0000_0040 (hit=1, pred=1, bias=1, ghr=0x5A). Resolve next cycle with is_jmp=1, decision=1, target=0x80. One cycle later, require:
  - index=0x10, tag=0x0, pht_idx=0x10, ghr=0x5A, target=0x80.
  - mispredict_o=0, count_o=0.
- Push 4 entries (DEPTH=4): IF_full_o=1. A 5th push is dropped and `err_o`=1. Push+resolve in the same cycle keeps count_o=4.
- Push A (pred=0), push B, then resolve A with decision=1 while pushing C: mispredict_o=1 next cycle, and count_o=0 (B and C discarded).
- JALR resolve (is_jmp=0, target=0x200) with 2 queued entries: packet is_jmp=0, decision=1, target=0x200; queue cleared; no pop error.
- `flush_i` concurrent with push on count=3: count_o=0 next cycle, `err_o` stays 0. Resolve on empty afterwards sets `err_o`=1.
- With `BR_COMMIT_STATS_EN`, run 10 resolves with 3 mispredicts: stat_branches_o=10, stat_mispred_o=3. Without the macro, both read 0.
